// File: rtl/therm_pkg.sv
// Shared defaults for the thermometer decoder: code width, error counter width,
// and the decoded-level width helper.
package therm_pkg;

   localparam int N_DEFAULT     = 5;
   localparam int ERR_W_DEFAULT = 8;

   // Width needed to represent levels 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/therm_first_one.sv
// Purpose: lowest-one index and bubble detection for a thermometer code.
// Latency: purely combinational. Backpressure: none, no state.
module therm_first_one #(
   parameter int N  = 5,
   parameter int CW = 3
)(
   input  logic [N-1:0]  code,
   output logic [CW-1:0] count,
   output logic          bubble
);

   logic seen_one;

   always_comb begin
      count = CW'(N);
      for (int i = N - 1; i >= 0; i--) begin
         if (code[i]) count = CW'(i);
      end
   end

   // A zero sitting anywhere above the first one breaks the thermometer shape.
   always_comb begin
      seen_one = 1'b0;
      bubble   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (seen_one && !code[i]) bubble = 1'b1;
         if (code[i]) seen_one = 1'b1;
      end
   end

endmodule

// File: rtl/therm_decoder.sv
// Purpose: two-stage thermometer-to-level decoder; THERM_DECODER_BUBBLE_CNT_EN adds a bubble counter.
// Latency: out_valid 2 cycles after acceptance, 1 result/cycle.
// Backpressure: valid/ready per stage; outputs hold while out_ready is low.
module therm_decoder
   import therm_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int ERR_W = ERR_W_DEFAULT,
   localparam int CW   = cnt_width(N)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [N-1:0]     in_therm,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_count,
   output logic             out_bubble,
   output logic [ERR_W-1:0] err_count
);

   logic          s1_valid;
   logic [N-1:0]  s1_code;
   logic          s2_adv;
   logic [CW-1:0] dec_count;
   logic          dec_bubble;

   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;

   therm_first_one #(
      .N  (N),
      .CW (CW)
   ) u_first_one (
      .code   (s1_code),
      .count  (dec_count),
      .bubble (dec_bubble)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) s1_code <= in_therm;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_count  <= '0;
         out_bubble <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_count  <= dec_count;
            out_bubble <= dec_bubble;
         end
      end
   end

`ifdef THERM_DECODER_BUBBLE_CNT_EN
   // Counts only results that actually leave, saturating at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
      end else if (out_valid && out_ready && out_bubble && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_therm_decoder.sv
// Directed-vector bench for therm_decoder with N=5, ERR_W=8.
module tb_therm_decoder;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [4:0] in_therm;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_count;
   logic       out_bubble;
   logic [7:0] err_count;

   int pass_cnt = 0;
   int chk_cnt  = 0;

`ifdef THERM_DECODER_BUBBLE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   therm_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_therm   (in_therm),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_count  (out_count),
      .out_bubble (out_bubble),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_therm = 5'b0; out_ready = 1'b0;
      #3;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else pass_cnt++;
      chk_cnt++; if (out_count !== 3'd0) $display("FAIL reset_out_count: got %0d required 0", out_count); else pass_cnt++;
      chk_cnt++; if (out_bubble !== 1'b0) $display("FAIL reset_out_bubble: got %b required 0", out_bubble); else pass_cnt++;
      chk_cnt++; if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d required 0", err_count); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else pass_cnt++;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_decode(input logic [4:0] code, input logic [2:0] exp_cnt, input logic exp_bub);
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_therm  = code;
      #1;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL dec_in_ready code=%b: got %b required 1", code, in_ready); else pass_cnt++;
      step();
      in_valid = 1'b0;
      in_therm = 5'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
         step();
         lat++;
      end
      chk_cnt++; if (lat !== 2) $display("FAIL dec_latency code=%b: got %0d required 2", code, lat); else pass_cnt++;
      chk_cnt++; if (out_count !== exp_cnt) $display("FAIL dec_count code=%b: got %0d required %0d", code, out_count, exp_cnt); else pass_cnt++;
      chk_cnt++; if (out_bubble !== exp_bub) $display("FAIL dec_bubble code=%b: got %b required %b", code, out_bubble, exp_bub); else pass_cnt++;
      step();
   endtask

   task automatic test_bubble_counter();
      logic [7:0] exp_after;
      exp_after = CNT_EN ? 8'd1 : 8'd0;
      chk_cnt++; if (err_count !== 8'd0) $display("FAIL err_before_bubble: got %0d required 0", err_count); else pass_cnt++;
      test_decode(5'b10100, 3'd2, 1'b1);
      chk_cnt++; if (err_count !== exp_after) $display("FAIL err_after_bubble: got %0d required %0d", err_count, exp_after); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [2:0] got[$];
      logic       acc;
      logic [4:0] codes [3];
      codes[0] = 5'b11100; codes[1] = 5'b11000; codes[2] = 5'b10000;
      out_ready = 1'b0;
      in_valid  = 1'b1; in_therm = codes[0];
      step();
      in_therm = codes[1];
      step();
      in_therm = codes[2];
      #1;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready_low: got %b required 0", in_ready); else pass_cnt++;
      for (int c = 0; c < 3; c++) begin
         chk_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_hold_valid cyc%0d: got %b required 1", c, out_valid); else pass_cnt++;
         chk_cnt++; if (out_count !== 3'd2) $display("FAIL b2b_hold_count cyc%0d: got %0d required 2", c, out_count); else pass_cnt++;
         chk_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_hold_in_ready cyc%0d: got %b required 0", c, in_ready); else pass_cnt++;
         step();
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && got.size() < 3; c++) begin
         #1;
         acc = in_valid && in_ready;
         if (out_valid) got.push_back(out_count);
         step();
         if (acc) in_valid = 1'b0;
      end
      chk_cnt++; if (got.size() !== 3) $display("FAIL b2b_result_count: got %0d required 3", got.size()); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         logic [2:0] g;
         g = (i < got.size()) ? got[i] : 3'd7;
         chk_cnt++; if (g !== 3'(i + 2)) $display("FAIL b2b_order idx%0d: got %0d required %0d", i, g, i + 2); else pass_cnt++;
      end
      in_valid = 1'b0;
      step(); step();
   endtask

   task automatic test_saturation();
      logic [7:0] exp_err;
      exp_err = CNT_EN ? 8'd255 : 8'd0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_therm  = 5'b10100;
      for (int i = 0; i < 300; i++) step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk_cnt++; if (err_count !== exp_err) $display("FAIL err_saturate: got %0d required %0d", err_count, exp_err); else pass_cnt++;
   endtask

   task automatic test_reset_midflight();
      int stale;
      out_ready = 1'b0;
      in_valid = 1'b1; in_therm = 5'b11110;
      step();
      in_therm = 5'b11111;
      step();
      in_valid = 1'b0;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL mid_full_valid: got %b required 1", out_valid); else pass_cnt++;
      rst = 1'b1;
      #1;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b required 1", in_ready); else pass_cnt++;
      chk_cnt++; if (out_count !== 3'd0) $display("FAIL mid_rst_out_count: got %0d required 0", out_count); else pass_cnt++;
      chk_cnt++; if (err_count !== 8'd0) $display("FAIL mid_rst_err_count: got %0d required 0", err_count); else pass_cnt++;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (out_valid !== 1'b0) stale++;
      end
      chk_cnt++; if (stale !== 0) $display("FAIL mid_rst_stale: got %0d stale cycles required 0", stale); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_decode(5'b11100, 3'd2, 1'b0);
      test_decode(5'b00000, 3'd5, 1'b0);
      test_decode(5'b11111, 3'd0, 1'b0);
      test_decode(5'b10000, 3'd4, 1'b0);
      test_bubble_counter();
      test_back_to_back();
      test_saturation();
      test_reset_midflight();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/therm_decoder.md
THERM_DECODER -- requirements
Module: therm_decoder

Interface
REQ-001 SHALL have parameter N, default 5, meaning thermometer code width in bits (N >= 2).
REQ-002 SHALL have parameter ERR_W, default 8, meaning width of the bubble error counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all flops update on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning the upstream code is valid.
REQ-006 SHALL have port in_therm, input, N, meaning the thermometer code: bits below the level are 0, the rest are 1.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts the input this cycle.
REQ-008 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-009 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-010 SHALL have port out_count, output, CW = $clog2(N+1), meaning the decoded level.
REQ-011 SHALL have port out_bubble, output, 1, meaning the accepted code was malformed.
REQ-012 SHALL have port err_count, output, ERR_W, meaning the number of bubbles seen (see Configuration).

Function
REQ-013 SHALL accept an input on a cycle where in_valid and in_ready are both high.
REQ-014 SHALL emit a result on a cycle where out_valid and out_ready are both high.
REQ-015 SHALL set out_count to the index of the lowest 1 bit of in_therm, or to N if in_therm is all zeros.
REQ-016 SHALL set out_bubble = 1 when any 0 bit lies above the lowest 1 bit; out_count SHALL still follow REQ-015 in that case.
REQ-017 SHALL be a two-stage pipeline:
  - S1 registers the raw code.
  - S2 registers out_count and out_bubble.
  - Each stage has its own valid flop.
REQ-018 SHALL raise out_valid exactly 2 cycles after an accepted input when out_ready is held high, with throughput of 1 result per cycle.
REQ-019 SHALL apply these advance rules:
  - S2 loads when (!s2_valid || out_ready).
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
REQ-020 SHALL keep out_valid, out_count and out_bubble stable while out_valid=1 and out_ready=0.
REQ-021 SHALL NOT lose or duplicate a code under backpressure; results SHALL leave in acceptance order.
REQ-022 SHALL NOT make in_ready depend on in_valid.
REQ-023 SHALL tolerate in_therm changing while in_valid=0; such values are ignored.

Reset
REQ-024 SHALL, on rst high, immediately clear:
  - both stage valids, out_count, out_bubble, err_count, all to 0;
  - in_ready SHALL read 1.
REQ-025 SHALL discard any data in flight when reset asserts mid-operation; no stale result SHALL appear after reset release.

Configuration
REQ-026 SHALL use macro THERM_DECODER_BUBBLE_CNT_EN to include or exclude the bubble error counter.
  - Defined: err_count increments by 1 on each emitted result with out_bubble=1 and saturates at all-ones.
  - Not defined: the counter logic is absent and err_count is tied to 0.

Structure
REQ-027 SHALL take N default, the CW width function and ERR_W default from shared package therm_pkg.
REQ-028 SHALL place the combinational lowest-one and bubble detection in sub-module therm_first_one, which has no state.

Verification
REQ-029 Bench SHALL cover the following with N=5:
  - in_therm=5'b11100, out_ready=1 -> out_count=2, out_bubble=0, out_valid exactly 2 cycles after acceptance.
  - in_therm=5'b00000 -> 5; 5'b11111 -> 0; 5'b10000 -> 4; all with out_bubble=0.
  - in_therm=5'b10100 -> out_count=2, out_bubble=1; err_count goes 0->1 with macro defined and stays 0 without it.
  - Back-to-back codes 2,3,4 with out_ready=0 for 3 cycles -> in_ready low after 2 accepts, outputs held, then 2,3,4 in order with no loss.
  - 300 bubble codes with macro defined -> err_count saturates at 255.
  - rst pulsed while both stages are full -> out_valid=0 at once, no stale output after release.
